// File: rtl/event_timestamp_tagger.sv
// Tags synchronised rising edges of an asynchronous detector input with the
// current timestamp and streams the stamps out through a small FIFO.
module event_timestamp_tagger #(
    parameter int unsigned TIMESTAMP_WIDTH  = 64,
    parameter int unsigned FIFO_DEPTH       = 16,
    parameter int unsigned DROP_COUNT_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          run,
    input  logic [TIMESTAMP_WIDTH-1:0]    timestamp,
    input  logic                          event_in,
    input  logic                          clear_stats,
    output logic [TIMESTAMP_WIDTH-1:0]    m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DROP_COUNT_WIDTH-1:0]   dropped_count,
    output logic                          overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    logic                       s1, s2, s3;
    logic                       ev_c;
    logic                       full_c;
    logic                       pop_c;
    logic                       push_c;
    logic                       drop_c;
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic [AW-1:0]              rd_next_c;
    logic [LW-1:0]              level_next_c;
    logic [TIMESTAMP_WIDTH-1:0] head_next_c;
    logic [TIMESTAMP_WIDTH-1:0] mem [FIFO_DEPTH];

    // Three-flop synchroniser; the last stage only serves edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= event_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Push/pop decisions; a pop in the same cycle frees room for a push when full.
    always_comb begin
        ev_c   = s2 & ~s3;
        full_c = (fifo_level == LW'(FIFO_DEPTH));
        pop_c  = m_axis_tvalid & m_axis_tready;
        push_c = ev_c & run & (~full_c | pop_c);
        drop_c = ev_c & run & full_c & ~pop_c;
    end

    // Next head pointer, level, and head word so tdata/tvalid can be registered.
    always_comb begin
        rd_next_c    = pop_c ? rd_ptr + AW'(1) : rd_ptr;
        level_next_c = fifo_level;
        if (push_c && !pop_c) begin
            level_next_c = fifo_level + LW'(1);
        end else if (pop_c && !push_c) begin
            level_next_c = fifo_level - LW'(1);
        end
        if (push_c && (rd_next_c == wr_ptr)) begin
            head_next_c = timestamp;
        end else begin
            head_next_c = mem[rd_next_c];
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= timestamp;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr        <= rd_next_c;
            fifo_level    <= level_next_c;
            m_axis_tvalid <= (level_next_c != '0);
            m_axis_tdata  <= head_next_c;
        end
    end

    // Drop statistics; a clear in the same cycle as a drop takes priority.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dropped_count <= '0;
            overflow      <= 1'b0;
        end else if (clear_stats) begin
            dropped_count <= '0;
            overflow      <= 1'b0;
        end else if (drop_c) begin
            if (!(&dropped_count)) begin
                dropped_count <= dropped_count + DROP_COUNT_WIDTH'(1);
            end
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_event_timestamp_tagger.sv
// Self-checking bench for event_timestamp_tagger: directed corner cases, a
// vector table for run gating, and random traffic against a queue model.
module tb_event_timestamp_tagger;

    localparam int unsigned TW    = 64;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned DCW   = 4;
    localparam int unsigned LW    = 5;
    localparam int unsigned DMAX  = (1 << DCW) - 1;

    logic           clk;
    logic           resetn;
    logic           run;
    logic [TW-1:0]  timestamp;
    logic           event_in;
    logic           clear_stats;
    logic [TW-1:0]  m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
    logic [LW-1:0]  fifo_level;
    logic [DCW-1:0] dropped_count;
    logic           overflow;

    event_timestamp_tagger #(
        .TIMESTAMP_WIDTH (TW),
        .FIFO_DEPTH      (DEPTH),
        .DROP_COUNT_WIDTH(DCW)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .run          (run),
        .timestamp    (timestamp),
        .event_in     (event_in),
        .clear_stats  (clear_stats),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .fifo_level   (fifo_level),
        .dropped_count(dropped_count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: event history, a queue of stamps and drop statistics.
    logic [TW-1:0] mq[$];
    int unsigned   m_drop;
    bit            m_ovf;
    bit            h1, h2, h3;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mq.delete();
            m_drop = 0;
            m_ovf  = 1'b0;
            h1 = 1'b0;
            h2 = 1'b0;
            h3 = 1'b0;
        end else begin
            bit ev;
            bit drop;
            ev   = h2 & ~h3;
            drop = 1'b0;
            if (mq.size() != 0 && m_axis_tready) void'(mq.pop_front());
            if (ev && run) begin
                if (mq.size() < DEPTH) mq.push_back(timestamp);
                else drop = 1'b1;
            end
            if (clear_stats) begin
                m_drop = 0;
                m_ovf  = 1'b0;
            end else if (drop) begin
                if (m_drop < DMAX) m_drop++;
                m_ovf = 1'b1;
            end
            h3 = h2;
            h2 = h1;
            h1 = event_in;
        end
    end

    always @(negedge clk) begin
        check("tvalid", 64'(m_axis_tvalid), 64'(mq.size() != 0));
        check("level", 64'(fifo_level), 64'(mq.size()));
        if (mq.size() != 0) check("tdata", m_axis_tdata, mq[0]);
        check("dropped", 64'(dropped_count), 64'(m_drop));
        check("overflow", 64'(overflow), 64'(m_ovf));
    end

    // Beat monitor: count accepted beats and require increasing stamps.
    int            beats = 0;
    logic [TW-1:0] last_beat = '0;
    bit            have_last = 1'b0;

    always @(posedge clk) begin
        if (resetn && m_axis_tvalid && m_axis_tready) begin
            if (have_last) check("order", 64'(m_axis_tdata > last_beat), 64'd1);
            last_beat = m_axis_tdata;
            have_last = 1'b1;
            beats++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        timestamp = timestamp + 1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input int hi, input int lo);
        event_in = 1'b1;
        ticks(hi);
        event_in = 1'b0;
        ticks(lo);
    endtask

    task automatic drain();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 200 && m_axis_tvalid; i++) tick();
        check("drain_done", 64'(m_axis_tvalid), 64'd0);
    endtask

    typedef struct {
        bit run;
        int pulses;
        int exp_beats;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int            b0;
        int            d0;
        logic [TW-1:0] exp_ts;

        vecs[0] = '{run: 1'b0, pulses: 3, exp_beats: 0};
        vecs[1] = '{run: 1'b1, pulses: 1, exp_beats: 1};
        vecs[2] = '{run: 1'b1, pulses: 3, exp_beats: 3};
        vecs[3] = '{run: 1'b0, pulses: 2, exp_beats: 0};

        resetn = 1'b0; run = 1'b0; event_in = 1'b0; clear_stats = 1'b0;
        m_axis_tready = 1'b0; timestamp = 90;
        ticks(3);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_tdata", m_axis_tdata, 64'd0);
        check("rst_dropped", 64'(dropped_count), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        resetn = 1'b1;
        run    = 1'b1;

        // First word: sampled at ts=200, stored as 202, visible after the write edge.
        for (int i = 0; i < 500 && timestamp != 200; i++) tick();
        check("reach_ts200", timestamp, 64'd200);
        event_in = 1'b1;
        ticks(2);
        check("first_not_early", 64'(m_axis_tvalid), 64'd0);
        tick();
        check("first_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("first_tdata", m_axis_tdata, 64'd202);
        check("first_level", 64'(fifo_level), 64'd1);
        event_in = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        check("first_popped", 64'(fifo_level), 64'd0);
        m_axis_tready = 1'b0;
        ticks(3);

        // Fill to full under backpressure, then one overflowing event.
        exp_ts = timestamp + 2;
        repeat (DEPTH) pulse(2, 2);
        ticks(2);
        check("fill_level", 64'(fifo_level), 64'(DEPTH));
        check("fill_head", m_axis_tdata, exp_ts);
        pulse(2, 2);
        ticks(2);
        check("drop_count1", 64'(dropped_count), 64'd1);
        check("drop_ovf1", 64'(overflow), 64'd1);
        check("drop_level", 64'(fifo_level), 64'(DEPTH));
        b0 = beats;
        drain();
        check("drain_beats", 64'(beats - b0), 64'(DEPTH));

        // Full FIFO, event lands on the same edge as a pop: no drop.
        m_axis_tready = 1'b0;
        repeat (DEPTH) pulse(2, 2);
        ticks(2);
        check("refill_level", 64'(fifo_level), 64'(DEPTH));
        d0 = int'(dropped_count);
        event_in = 1'b1;
        ticks(2);
        m_axis_tready = 1'b1;
        exp_ts = timestamp;
        b0 = beats;
        tick();
        event_in = 1'b0;
        check("coinc_level", 64'(fifo_level), 64'(DEPTH));
        check("coinc_nodrop", 64'(dropped_count), 64'(d0));
        drain();
        check("coinc_beats", 64'(beats - b0), 64'(DEPTH + 1));
        check("coinc_last", last_beat, exp_ts);

        // Saturation of the drop counter and clear priority.
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        check("clr_count", 64'(dropped_count), 64'd0);
        check("clr_ovf", 64'(overflow), 64'd0);
        m_axis_tready = 1'b0;
        repeat (DEPTH) pulse(2, 2);
        repeat (20) pulse(2, 2);
        ticks(2);
        check("sat_count", 64'(dropped_count), 64'(DMAX));
        check("sat_ovf", 64'(overflow), 64'd1);
        check("sat_level", 64'(fifo_level), 64'(DEPTH));
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        check("sat_clr_count", 64'(dropped_count), 64'd0);
        check("sat_clr_ovf", 64'(overflow), 64'd0);
        event_in = 1'b1;
        ticks(2);
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        event_in = 1'b0;
        check("clr_vs_drop_count", 64'(dropped_count), 64'd0);
        check("clr_vs_drop_ovf", 64'(overflow), 64'd0);
        ticks(2);
        pulse(2, 2);
        ticks(2);
        check("post_clr_drop", 64'(dropped_count), 64'd1);
        drain();

        // Run gating vectors.
        for (int v = 0; v < 4; v++) begin
            run = vecs[v].run;
            m_axis_tready = 1'b1;
            b0 = beats;
            d0 = int'(dropped_count);
            repeat (vecs[v].pulses) pulse(3, 3);
            ticks(4);
            check($sformatf("vec%0d_beats", v), 64'(beats - b0), 64'(vecs[v].exp_beats));
            check($sformatf("vec%0d_dropped", v), 64'(dropped_count), 64'(d0));
        end
        run = 1'b1;

        // Asynchronous reset with five stamps buffered.
        m_axis_tready = 1'b0;
        repeat (5) pulse(2, 2);
        ticks(2);
        check("pre_rst_level", 64'(fifo_level), 64'd5);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("arst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("arst_level", 64'(fifo_level), 64'd0);
        check("arst_dropped", 64'(dropped_count), 64'd0);
        check("arst_ovf", 64'(overflow), 64'd0);
        check("arst_tdata", m_axis_tdata, 64'd0);
        ticks(2);
        resetn = 1'b1;
        ticks(2);
        exp_ts = timestamp + 2;
        event_in = 1'b1;
        ticks(3);
        check("post_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("post_rst_tdata", m_axis_tdata, exp_ts);
        event_in = 1'b0;
        ticks(2);
        drain();

        // Random traffic against the model.
        for (int p = 0; p < 150; p++) begin
            int hi;
            int lo;
            hi  = int'($urandom_range(2, 5));
            lo  = int'($urandom_range(2, 6));
            run = ($urandom_range(0, 9) != 0);
            event_in = 1'b1;
            for (int t = 0; t < hi + lo; t++) begin
                if (t == hi) event_in = 1'b0;
                m_axis_tready = ($urandom_range(0, 2) == 0);
                clear_stats   = ($urandom_range(0, 24) == 0);
                tick();
            end
        end
        clear_stats = 1'b0;
        run = 1'b1;
        ticks(4);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/event_timestamp_tagger.md
Name: event_timestamp_tagger

Overview:
- Consumes the free-running cycle-count timestamp bus and tags asynchronous detector events with it.
- Each rising edge on the detector input is synchronised and stamped with the timestamp value current on the capture cycle.
- Stamped events are buffered in a small FIFO and delivered downstream over an AXI4-Stream master port.
- Sits between the timestamp counter and the DMA/packetiser stage; reports dropped events on FIFO overflow.

Parameters:
- TIMESTAMP_WIDTH, 64, width of timestamp input and of output data.
- FIFO_DEPTH, 16, event buffer entries; power of two, minimum 2.
- DROP_COUNT_WIDTH, 32, width of saturating dropped-event counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- run  in  1  capture enable; same signal that gates the timestamp counter.
- timestamp  in  TIMESTAMP_WIDTH  current cycle count from the timestamp counter.
- event_in  in  1  asynchronous detector pulse; minimum high and low time of 2 clk periods each.
- clear_stats  in  1  synchronous one-cycle pulse; clears dropped_count and overflow.
- m_axis_tdata  out  TIMESTAMP_WIDTH  timestamp of the oldest buffered event.
- m_axis_tvalid  out  1  FIFO not empty.
- m_axis_tready  in  1  downstream accept.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
- dropped_count  out  DROP_COUNT_WIDTH  events lost to a full FIFO; saturates.
- overflow  out  1  sticky; set on the first drop.

Behaviour:
- Reset: asynchronous assert when resetn=0.
  - All sync flops, FIFO pointers and fifo_level clear to 0.
  - dropped_count=0, overflow=0, m_axis_tvalid=0, m_axis_tdata=0.
  - Release is synchronous to clk.
  - Reset mid-operation discards all buffered events.
- Synchroniser: event_in → s1 → s2 → s3 (three flops).
  - Edge pulse ev = s2 & ~s3, high for exactly one cycle per rising edge of event_in.
- Capture latency:
  - event_in sampled high at edge k gives ev=1 during cycle k+2.
  - The write occurs at edge k+2, storing the timestamp value present on the bus at that edge (pre-increment value).
  - Fixed offset: two cycles from the sampling edge; software subtracts it.
- Gating: ev is ignored (no write, no drop count) when run=0. A rising edge whose ev cycle falls with run=0 is lost silently.
- FIFO:
  - Write when ev & run & (not full, or pop in the same cycle).
  - Pop when m_axis_tvalid & m_axis_tready.
  - m_axis_tvalid = (fifo_level != 0).
  - m_axis_tdata shows the head entry and holds stable while tvalid=1 and tready=0.
  - First word: a write into an empty FIFO at edge E gives tvalid=1 in the cycle after E. No write-to-read bypass within the same cycle.
  - Simultaneous push and pop: level unchanged. This applies when full too, and no drop occurs then.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level is updated on the same edge as the push/pop.
- Drop: ev & run & full & no pop.
  - Event discarded and FIFO contents unchanged.
  - dropped_count increments; it saturates at all-ones and does not wrap.
  - overflow is set to 1.
- clear_stats: at the next edge, dropped_count=0 and overflow=0.
  - If a drop occurs in the same cycle, clear wins: count=0, overflow=0.
  - FIFO is unaffected.
- run falling: no new captures. Buffered events keep draining normally.
- Timestamp wrap: no special handling; the stored value is whatever is on the bus.

Test Plan:
- Reset, run=1, timestamp driven 100,101,…; event_in rises, sampled at the edge where timestamp=200 → one beat, tdata=202, tvalid high in the cycle after capture; level 1→0 on accept.
- tready=0, 16 events spaced 4 cycles apart → level=16, tvalid=1, tdata stable at first stamp; a 17th event → dropped_count=1, overflow=1, level stays 16; release tready → 16 beats in order, strictly increasing.
- FIFO full, tready=1 held, event's ev cycle coincides with a pop → no drop, level stays 16, the new stamp appears as the last beat.
- run=0 with 3 event pulses → no beats, dropped_count=0; run=1 then 1 pulse → exactly one beat.
- dropped_count preloaded near max (DROP_COUNT_WIDTH=4 build, 20 drops) → saturates at 15; clear_stats pulse → 0 and overflow=0; clear coincident with a drop → 0.
- resetn asserted asynchronously mid-burst with level=5 → tvalid, level and counters go to 0 immediately, before the next edge; after release, the first new event is stamped correctly.
